fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/cla_16b.sv | 56 +++++
 rtl/fetch_stage.sv | 72 +++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared state encoding and constants for the fetch stage
package fetch_stage_pkg;

    typedef enum logic [2:0] {
        REQ  = 3'd0,
        WAIT = 3'd1,
        HOLD = 3'd2,
        NEXT = 3'd3,
        HALT = 3'd4,
        ERR  = 3'd5
    } fetch_state_t;

    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam logic [15:0] RESET_PC    = 16'h0000;
    localparam logic [15:0] PC_INCR     = 16'h0002;

endpackage

// File: rtl/cla_16b.sv
// rtl/cla_16b.sv - 16-bit carry-lookahead adder built from four 4-bit lookahead groups
module cla_16b (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);

    // Carries out of each of four positions, given generate/propagate and a carry in.
    function automatic logic [3:0] look4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [3:0]  grp_c;
    logic [3:0]  grp_cin;
    logic [3:0]  t;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        grp_g   = '0;
        grp_p   = '0;
        grp_c   = '0;
        grp_cin = '0;
        c       = '0;
        t       = '0;
        for (int i = 0; i < 4; i++) begin
            t        = look4(g[i*4 +: 4], p[i*4 +: 4], 1'b0);
            grp_g[i] = t[3];
            grp_p[i] = &p[i*4 +: 4];
        end
        grp_c   = look4(grp_g, grp_p, c_in);
        grp_cin = {grp_c[2:0], c_in};
        for (int i = 0; i < 4; i++) begin
            t          = look4(g[i*4 +: 4], p[i*4 +: 4], grp_cin[i]);
            c[i*4 +: 4] = {t[2:0], grp_cin[i]};
        end
    end

    assign sum   = p ^ c;
    assign c_out = grp_c[3];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM holding one instruction for decode
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] newPC,
    input  logic        newPC_vld,
    input  logic        instr_rdy,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        imem_err,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    output logic [15:0] Instr,
    output logic        instr_vld,
    output logic [15:0] PC,
    output logic [15:0] PCinc,
    output logic        halted,
    output logic        err
);

    fetch_state_t state;
    fetch_state_t next_state;
    logic         unused_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            PC    <= RESET_PC;
            Instr <= 16'h0000;
        end else begin
            state <= next_state;
            if (state == WAIT && imem_done && !imem_err) begin
                Instr <= imem_rdata;
            end
            if (state == NEXT && newPC_vld) begin
                PC <= newPC;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            REQ:     next_state = PC[0] ? ERR : WAIT;
            WAIT:    if (imem_done) next_state = imem_err ? ERR : HOLD;
            HOLD:    if (instr_rdy) next_state = (Instr[15:11] == HALT_OPCODE) ? HALT : NEXT;
            NEXT:    if (newPC_vld) next_state = REQ;
            HALT:    next_state = HALT;
            ERR:     next_state = ERR;
            default: next_state = ERR;
        endcase
    end

    // Gated by rst so no read escapes while reset is held with the FSM parked in REQ.
    assign imem_rd   = (state == REQ) && !PC[0] && !rst;
    assign imem_addr = PC;
    assign instr_vld = (state == HOLD);
    assign halted    = (state == HALT);
    assign err       = (state == ERR);

    // Wraps modulo 2^16; the carry out is deliberately dropped.
    cla_16b u_pc_inc (
        .a     (PC),
        .b     (PC_INCR),
        .c_in  (1'b0),
        .sum   (PCinc),
        .c_out (unused_cout)
    );

endmodule
